// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full_adder cell produces one result bit per clock, LSB first.
// A three-state controller (IDLE/RUN/DONE) sequences the operand shifts and pulses done.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // Counter must hold the value WIDTH after the last RUN edge.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_sum, fa_cout;

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .c    (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d              = a_sr_q >> 1;
                b_sr_d              = b_sr_q >> 1;
                res_sr_d            = res_sr_q >> 1;
                res_sr_d[WIDTH-1]   = fa_sum;
                carry_d             = fa_cout;
                cnt_d               = cnt_q + CNT_W'(1);
                // The final bit is folded into sum on the same edge it is produced.
                if (cnt_q == LAST_CNT) begin
                    sum_d   = res_sr_d;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be legal for any WIDTH >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress (RUN state).
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 sum  output  WIDTH  registered result of a + b + cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 The block SHALL contain exactly one instance of the team's full_adder cell (ports a, b, c, sum, cout) and SHALL compute every result bit with that instance, one bit per clock, LSB first.
REQ-013 FSM states SHALL be IDLE, RUN and DONE; the state after reset SHALL be IDLE.
REQ-014 IDLE: start=1 SHALL load a and b into internal shift registers, load the carry register with cin, clear the bit counter and enter RUN; start=0 SHALL hold IDLE.
REQ-015 RUN: on each edge the cell inputs SHALL be a_sr[0], b_sr[0] and the carry register; the cell sum SHALL shift into the MSB of the result shift register; the cell cout SHALL load the carry register; a_sr and b_sr SHALL shift right by one; the counter SHALL increment.
REQ-016 RUN SHALL last exactly WIDTH clock cycles; on the WIDTH-th RUN edge the FSM SHALL enter DONE.
REQ-017 On the edge entering DONE, sum SHALL load the completed result (including the final shifted bit) and cout SHALL load the final cell carry-out; at all other times sum and cout SHALL hold their values.
REQ-018 DONE SHALL last one cycle with done=1, then return unconditionally to IDLE.
REQ-019 Latency: for start sampled at edge 0, done SHALL be high from edge WIDTH to edge WIDTH+1, and sum/cout SHALL be valid from edge WIDTH onward.
REQ-020 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-021 start SHALL be ignored in RUN and DONE; no request queuing; the minimum start-to-start spacing SHALL be WIDTH+2 cycles.
REQ-022 a, b and cin SHALL be don't-care except on the edge where start is accepted; changes during RUN SHALL NOT affect the result.
REQ-023 The bit counter SHALL be sized to count to WIDTH without overflow; WIDTH=1 SHALL give one RUN cycle.

Reset
REQ-024 rst=1 SHALL override start and all FSM activity, and SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and shift registers.
REQ-025 Reset during RUN or DONE SHALL abandon the operation with no done pulse; the next start after rst falls SHALL complete normally.

Verification (WIDTH=8 unless stated)
REQ-026 Release reset, no start -> busy=0, done=0, sum=0x00, cout=0 held for 20 cycles.
REQ-027 a=0xFF, b=0x01, cin=0, start at edge 0 -> busy high for edges 1..8, done=1 only between edges 8 and 9, sum=0x00, cout=1.
REQ-028 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; then a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0; sum holds 0x00 until the second done.
REQ-029 start held high continuously, with a/b changed at every edge during RUN -> only the operands captured at acceptance are used; the next operation starts at the first IDLE edge after DONE.
REQ-030 rst asserted at edge 4 of an operation -> no done pulse, outputs 0, FSM IDLE; a following 0x12+0x34, cin=0 -> sum=0x46, cout=0.
REQ-031 WIDTH=3: all 128 combinations of a, b and cin checked against a + b + cin -> {cout,sum} match exactly, done latency = 3.
